// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the IFU request/response channel, the LSU
// request/response channel and the shared data-memory port.
//   slave  - arbiter view: takes requests and mem_rdata, drives readies,
//            responses and the memory port.
//   master - environment view: IFU, LSU and memory side, directions mirrored.
interface mem_arbiter_if;
    // IFU channel
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_rdata;
    // LSU channel
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic [2:0]  lsu_readop;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_rdata;
    // Memory port
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [2:0]  mem_readop;
    logic [31:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_readop, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata,
        output mem_wmask, mem_readop
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_readop, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata,
        input  mem_wmask, mem_readop
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the instruction-fetch
// unit and the load/store unit. One request is accepted at a time, the
// memory port is driven for MEM_LAT cycles, and the result is returned to
// the owning master on its response channel. Ties are broken round-robin.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave: IFU/LSU request+response channels and
//           the memory port (see mem_arbiter_if.sv)
module mem_arbiter #(
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [2:0]  FETCH_OP = 3'h2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q,      owner_d;
    logic             wen_q,        wen_d;
    logic [31:0]      addr_q,       addr_d;
    logic [31:0]      wdata_q,      wdata_d;
    logic [7:0]       wmask_q,      wmask_d;
    logic [2:0]       readop_q,     readop_d;
    logic [CNT_W-1:0] lat_cnt_q,    lat_cnt_d;
    logic [31:0]      resp_q,       resp_d;

    logic grant_ifu;
    logic grant_lsu;
    logic in_idle;
    logic in_access;
    logic in_resp;
    logic first_access;
    logic rd_access;
    logic wr_access;

    // Round-robin: with both valid, the master that did not win last time goes.
    assign grant_ifu = bus.ifu_req_valid &
                       (!bus.lsu_req_valid || (last_grant_q == OWN_LSU));
    assign grant_lsu = bus.lsu_req_valid &
                       (!bus.ifu_req_valid || (last_grant_q == OWN_IFU));

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

    // Readies are gated by rst_n so every output is 0 while reset is held,
    // even though the request valids feed them combinationally.
    assign bus.ifu_req_ready = rst_n & in_idle & grant_ifu;
    assign bus.lsu_req_ready = rst_n & in_idle & grant_lsu;

    // The counter is loaded with MEM_LAT, so that value marks the first
    // ACCESS cycle, the only one in which the write strobe fires.
    assign first_access = (lat_cnt_q == CNT_W'(MEM_LAT));
    assign rd_access    = in_access & ~wen_q;
    assign wr_access    = in_access &  wen_q;

    assign bus.mem_valid  = rd_access;
    assign bus.mem_raddr  = rd_access ? addr_q   : 32'd0;
    assign bus.mem_readop = rd_access ? readop_q : 3'd0;
    assign bus.mem_wen    = wr_access & first_access;
    assign bus.mem_waddr  = wr_access ? addr_q   : 32'd0;
    assign bus.mem_wdata  = wr_access ? wdata_q  : 32'd0;
    assign bus.mem_wmask  = wr_access ? wmask_q  : 8'd0;

    assign bus.ifu_resp_valid = in_resp & (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = in_resp & (owner_q == OWN_LSU);
    assign bus.ifu_rdata      = bus.ifu_resp_valid ? resp_q : 32'd0;
    assign bus.lsu_rdata      = bus.lsu_resp_valid ? resp_q : 32'd0;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        readop_d     = readop_q;
        lat_cnt_d    = lat_cnt_q;
        resp_d       = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ifu_req_ready) begin
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    wen_d        = 1'b0;
                    addr_d       = bus.ifu_addr;
                    wdata_d      = 32'd0;
                    wmask_d      = 8'd0;
                    readop_d     = FETCH_OP;
                    lat_cnt_d    = CNT_W'(MEM_LAT);
                    state_d      = ST_ACCESS;
                end else if (bus.lsu_req_ready) begin
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    wen_d        = bus.lsu_wen;
                    addr_d       = bus.lsu_addr;
                    wdata_d      = bus.lsu_wdata;
                    wmask_d      = bus.lsu_wmask;
                    readop_d     = bus.lsu_readop;
                    lat_cnt_d    = CNT_W'(MEM_LAT);
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                lat_cnt_d = lat_cnt_q - CNT_W'(1);
                if (lat_cnt_q == CNT_W'(1)) begin
                    // Stores return a plain acknowledge with zero data.
                    resp_d  = wen_q ? 32'd0 : bus.mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if ((owner_q == OWN_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWN_LSU;
            owner_q      <= OWN_IFU;
            wen_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 8'd0;
            readop_q     <= 3'd0;
            lat_cnt_q    <= '0;
            resp_q       <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            readop_q     <= readop_d;
            lat_cnt_q    <= lat_cnt_d;
            resp_q       <= resp_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter.
// dut1 runs with MEM_LAT=1 from a per-cycle vector table; dut3 runs with
// MEM_LAT=3 through a hand-written reset-abort and latency sequence.
module tb_mem_arbiter;

    logic clk;
    logic rst1_n;
    logic rst3_n;

    int checks   = 0;
    int failures = 0;

    mem_arbiter_if if1 ();
    mem_arbiter_if if3 ();

    mem_arbiter #(.MEM_LAT(1), .FETCH_OP(3'h2)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));
    mem_arbiter #(.MEM_LAT(3), .FETCH_OP(3'h2)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One record per clock cycle: inputs applied after the rising edge,
    // expected outputs compared at the following falling edge.
    typedef struct {
        logic        ifu_v;
        logic [31:0] ifu_addr;
        logic        ifu_rr;
        logic        lsu_v;
        logic        lsu_wen;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        logic [7:0]  lsu_wmask;
        logic [2:0]  lsu_readop;
        logic        lsu_rr;
        logic [31:0] mem_rdata;
        logic        e_ifu_rdy;
        logic        e_lsu_rdy;
        logic        e_ifu_rv;
        logic [31:0] e_ifu_rdata;
        logic        e_lsu_rv;
        logic [31:0] e_lsu_rdata;
        logic        e_mvalid;
        logic        e_mwen;
        logic [31:0] e_raddr;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [2:0]  e_readop;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    localparam logic [31:0] IFA0 = 32'h8000_0004;
    localparam logic [31:0] IFB  = 32'h8000_0010;
    localparam logic [31:0] IFC  = 32'h8000_0014;
    localparam logic [31:0] SA   = 32'h8000_0100;
    localparam logic [31:0] SD   = 32'hDEAD_BEEF;
    localparam logic [31:0] LA   = 32'h8000_0200;
    localparam logic [31:0] LBA  = 32'h8000_0301;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input int i, input logic ifu_v, input logic [31:0] ifu_addr,
                          input logic ifu_rr, input logic lsu_v, input logic lsu_wen,
                          input logic [31:0] lsu_addr, input logic [31:0] lsu_wdata,
                          input logic [7:0] lsu_wmask, input logic [2:0] lsu_readop,
                          input logic lsu_rr, input logic [31:0] mem_rdata);
        vecs[i].ifu_v       = ifu_v;
        vecs[i].ifu_addr    = ifu_addr;
        vecs[i].ifu_rr      = ifu_rr;
        vecs[i].lsu_v       = lsu_v;
        vecs[i].lsu_wen     = lsu_wen;
        vecs[i].lsu_addr    = lsu_addr;
        vecs[i].lsu_wdata   = lsu_wdata;
        vecs[i].lsu_wmask   = lsu_wmask;
        vecs[i].lsu_readop  = lsu_readop;
        vecs[i].lsu_rr      = lsu_rr;
        vecs[i].mem_rdata   = mem_rdata;
        vecs[i].e_ifu_rdy   = 1'b0;
        vecs[i].e_lsu_rdy   = 1'b0;
        vecs[i].e_ifu_rv    = 1'b0;
        vecs[i].e_ifu_rdata = 32'd0;
        vecs[i].e_lsu_rv    = 1'b0;
        vecs[i].e_lsu_rdata = 32'd0;
        vecs[i].e_mvalid    = 1'b0;
        vecs[i].e_mwen      = 1'b0;
        vecs[i].e_raddr     = 32'd0;
        vecs[i].e_waddr     = 32'd0;
        vecs[i].e_wdata     = 32'd0;
        vecs[i].e_wmask     = 8'd0;
        vecs[i].e_readop    = 3'd0;
    endtask

    task automatic set_rdy(input int i, input logic ifu, input logic lsu);
        vecs[i].e_ifu_rdy = ifu;
        vecs[i].e_lsu_rdy = lsu;
    endtask

    task automatic set_resp(input int i, input logic ifu_rv, input logic [31:0] ifu_rdata,
                            input logic lsu_rv, input logic [31:0] lsu_rdata);
        vecs[i].e_ifu_rv    = ifu_rv;
        vecs[i].e_ifu_rdata = ifu_rdata;
        vecs[i].e_lsu_rv    = lsu_rv;
        vecs[i].e_lsu_rdata = lsu_rdata;
    endtask

    task automatic set_mem(input int i, input logic mvalid, input logic mwen,
                           input logic [31:0] raddr, input logic [31:0] waddr,
                           input logic [31:0] wdata, input logic [7:0] wmask,
                           input logic [2:0] readop);
        vecs[i].e_mvalid = mvalid;
        vecs[i].e_mwen   = mwen;
        vecs[i].e_raddr  = raddr;
        vecs[i].e_waddr  = waddr;
        vecs[i].e_wdata  = wdata;
        vecs[i].e_wmask  = wmask;
        vecs[i].e_readop = readop;
    endtask

    task automatic apply_vec(input int i);
        if1.ifu_req_valid  = vecs[i].ifu_v;
        if1.ifu_addr       = vecs[i].ifu_addr;
        if1.ifu_resp_ready = vecs[i].ifu_rr;
        if1.lsu_req_valid  = vecs[i].lsu_v;
        if1.lsu_wen        = vecs[i].lsu_wen;
        if1.lsu_addr       = vecs[i].lsu_addr;
        if1.lsu_wdata      = vecs[i].lsu_wdata;
        if1.lsu_wmask      = vecs[i].lsu_wmask;
        if1.lsu_readop     = vecs[i].lsu_readop;
        if1.lsu_resp_ready = vecs[i].lsu_rr;
        if1.mem_rdata      = vecs[i].mem_rdata;
    endtask

    task automatic check_vec(input int i);
        check($sformatf("v%0d_ifu_req_ready", i),  if1.ifu_req_ready,  vecs[i].e_ifu_rdy);
        check($sformatf("v%0d_lsu_req_ready", i),  if1.lsu_req_ready,  vecs[i].e_lsu_rdy);
        check($sformatf("v%0d_ifu_resp_valid", i), if1.ifu_resp_valid, vecs[i].e_ifu_rv);
        check($sformatf("v%0d_ifu_rdata", i),      if1.ifu_rdata,      vecs[i].e_ifu_rdata);
        check($sformatf("v%0d_lsu_resp_valid", i), if1.lsu_resp_valid, vecs[i].e_lsu_rv);
        check($sformatf("v%0d_lsu_rdata", i),      if1.lsu_rdata,      vecs[i].e_lsu_rdata);
        check($sformatf("v%0d_mem_valid", i),      if1.mem_valid,      vecs[i].e_mvalid);
        check($sformatf("v%0d_mem_wen", i),        if1.mem_wen,        vecs[i].e_mwen);
        check($sformatf("v%0d_mem_raddr", i),      if1.mem_raddr,      vecs[i].e_raddr);
        check($sformatf("v%0d_mem_waddr", i),      if1.mem_waddr,      vecs[i].e_waddr);
        check($sformatf("v%0d_mem_wdata", i),      if1.mem_wdata,      vecs[i].e_wdata);
        check($sformatf("v%0d_mem_wmask", i),      if1.mem_wmask,      vecs[i].e_wmask);
        check($sformatf("v%0d_mem_readop", i),     if1.mem_readop,     vecs[i].e_readop);
    endtask

    task automatic fill_vectors();
        // IFU fetch, LSU store waiting; IFU wins the first tie after reset.
        set_in(0, 1, IFA0, 1, 1, 1, SA, SD, 8'h0F, 3'd0, 1, 32'd0);           set_rdy(0, 1, 0);
        set_in(1, 0, IFA0, 1, 1, 1, SA, SD, 8'h0F, 3'd0, 1, 32'h0010_0093);
        set_mem(1, 1, 0, IFA0, 32'd0, 32'd0, 8'd0, 3'd2);
        set_in(2, 0, IFA0, 1, 1, 1, SA, SD, 8'h0F, 3'd0, 1, 32'd0);
        set_resp(2, 1, 32'h0010_0093, 0, 32'd0);
        // LSU store.
        set_in(3, 0, IFA0, 1, 1, 1, SA, SD, 8'h0F, 3'd0, 1, 32'd0);           set_rdy(3, 0, 1);
        set_in(4, 0, IFA0, 1, 0, 1, SA, SD, 8'h0F, 3'd0, 1, 32'h1234_5678);
        set_mem(4, 0, 1, 32'd0, SA, SD, 8'h0F, 3'd0);
        set_in(5, 0, IFA0, 1, 0, 1, SA, SD, 8'h0F, 3'd0, 1, 32'd0);
        set_resp(5, 0, 32'd0, 1, 32'd0);
        // Contention: both valid continuously, grants alternate.
        for (int k = 6; k <= 14; k++) begin
            set_in(k, 1, (k >= 12) ? IFC : IFB, 1, 1, 0, LA, 32'd0, 8'd0, 3'd2, 1, 32'd0);
        end
        set_rdy(6, 1, 0);
        vecs[7].mem_rdata = 32'h1111_1111;
        set_mem(7, 1, 0, IFB, 32'd0, 32'd0, 8'd0, 3'd2);
        set_resp(8, 1, 32'h1111_1111, 0, 32'd0);
        set_rdy(9, 0, 1);
        vecs[10].mem_rdata = 32'h2222_2222;
        set_mem(10, 1, 0, LA, 32'd0, 32'd0, 8'd0, 3'd2);
        set_resp(11, 0, 32'd0, 1, 32'h2222_2222);
        set_rdy(12, 1, 0);
        vecs[13].mem_rdata = 32'h3333_3333;
        set_mem(13, 1, 0, IFC, 32'd0, 32'd0, 8'd0, 3'd2);
        set_resp(14, 1, 32'h3333_3333, 0, 32'd0);
        // Fourth contended grant is an lbu that then sees backpressure.
        set_in(15, 1, IFC, 1, 1, 0, LBA, 32'd0, 8'd0, 3'd4, 0, 32'd0);        set_rdy(15, 0, 1);
        set_in(16, 1, IFC, 1, 0, 0, LBA, 32'd0, 8'd0, 3'd4, 0, 32'h0000_00F0);
        set_mem(16, 1, 0, LBA, 32'd0, 32'd0, 8'd0, 3'd4);
        for (int k = 17; k <= 22; k++) begin
            set_in(k, 1, IFC, 1, 0, 0, LBA, 32'd0, 8'd0, 3'd4, (k == 22) ? 1'b1 : 1'b0,
                   32'hFFFF_FFFF);
            set_resp(k, 0, 32'd0, 1, 32'h0000_00F0);
        end
        // Back in IDLE; resp_ready while idle has no effect.
        set_in(23, 1, IFC, 1, 0, 0, LBA, 32'd0, 8'd0, 3'd4, 1, 32'd0);        set_rdy(23, 1, 0);
    endtask

    task automatic idle_if3();
        if3.ifu_req_valid  = 1'b0;
        if3.ifu_addr       = 32'd0;
        if3.ifu_resp_ready = 1'b1;
        if3.lsu_req_valid  = 1'b0;
        if3.lsu_wen        = 1'b0;
        if3.lsu_addr       = 32'd0;
        if3.lsu_wdata      = 32'd0;
        if3.lsu_wmask      = 8'd0;
        if3.lsu_readop     = 3'd0;
        if3.lsu_resp_ready = 1'b1;
        if3.mem_rdata      = 32'd0;
    endtask

    initial begin
        int n_resp;
        int wen_cnt;
        int ifu_spur;

        fill_vectors();
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        apply_vec(0);
        idle_if3();
        if3.ifu_req_valid = 1'b1;
        if3.lsu_req_valid = 1'b1;

        // Reset held with both requests valid: every output must be 0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst1_outputs", {if1.ifu_req_ready, if1.lsu_req_ready, if1.ifu_resp_valid,
              if1.ifu_rdata, if1.lsu_resp_valid, if1.lsu_rdata, if1.mem_valid, if1.mem_wen,
              if1.mem_raddr, if1.mem_waddr, if1.mem_wdata, if1.mem_wmask, if1.mem_readop}, '0);
        check("rst3_outputs", {if3.ifu_req_ready, if3.lsu_req_ready, if3.ifu_resp_valid,
              if3.lsu_resp_valid, if3.mem_valid, if3.mem_wen}, '0);
        @(posedge clk);
        #1;
        idle_if3();
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // MEM_LAT=1 vector table.
        for (int i = 0; i < NVEC; i++) begin
            apply_vec(i);
            @(negedge clk);
            check_vec(i);
            @(posedge clk);
            #1;
        end
        if1.ifu_req_valid = 1'b0;
        if1.lsu_req_valid = 1'b0;

        // MEM_LAT=3: fetch aborted by a reset pulse in the 2nd ACCESS cycle.
        if3.ifu_req_valid = 1'b1;
        if3.ifu_addr      = 32'h8000_0040;
        if3.mem_rdata     = 32'hCAFE_0000;
        @(negedge clk);
        check("lat3_fetch_ready", if3.ifu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        if3.ifu_req_valid = 1'b0;
        @(negedge clk);
        check("lat3_access1_mem_valid", if3.mem_valid, 1'b1);
        check("lat3_access1_raddr", if3.mem_raddr, 32'h8000_0040);
        @(posedge clk);
        #1;
        check("lat3_access2_mem_valid", if3.mem_valid, 1'b1);
        rst3_n = 1'b0;
        #1;
        check("lat3_abort_outputs", {if3.ifu_req_ready, if3.lsu_req_ready, if3.ifu_resp_valid,
              if3.ifu_rdata, if3.lsu_resp_valid, if3.lsu_rdata, if3.mem_valid, if3.mem_wen,
              if3.mem_raddr, if3.mem_readop}, '0);
        @(negedge clk);
        #1;
        rst3_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("lat3_no_resp_%0d", k), {if3.ifu_resp_valid, if3.lsu_resp_valid}, 2'b00);
        end

        // MEM_LAT=3 store: response in the 5th cycle counting the handshake.
        @(posedge clk);
        #1;
        if3.lsu_req_valid = 1'b1;
        if3.lsu_wen       = 1'b1;
        if3.lsu_addr      = 32'h8000_0180;
        if3.lsu_wdata     = 32'h0BAD_F00D;
        if3.lsu_wmask     = 8'h3C;
        if3.mem_rdata     = 32'h5555_AAAA;
        @(negedge clk);
        check("lat3_store_ready", if3.lsu_req_ready, 1'b1);
        @(posedge clk);
        #1;
        if3.lsu_req_valid = 1'b0;
        n_resp   = 0;
        wen_cnt  = 0;
        ifu_spur = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (if3.mem_wen) wen_cnt++;
            if (if3.ifu_resp_valid) ifu_spur++;
            if (n == 1) begin
                check("lat3_first_wen", if3.mem_wen, 1'b1);
                check("lat3_waddr", if3.mem_waddr, 32'h8000_0180);
                check("lat3_wdata", if3.mem_wdata, 32'h0BAD_F00D);
                check("lat3_wmask", if3.mem_wmask, 8'h3C);
            end
            if (if3.lsu_resp_valid) begin
                n_resp = n;
                check("lat3_store_rdata", if3.lsu_rdata, 32'd0);
                break;
            end
        end
        check("lat3_resp_cycle", n_resp, 4);
        check("lat3_wen_count", wen_cnt, 1);
        check("lat3_ifu_spurious", ifu_spur, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat3_back_idle", if3.lsu_resp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
